// File: rtl/bist_mult5_core.sv
// BIST engine: two LFSRs feed a 5x5 array multiplier with stuck-at fault injection,
// and a MISR compacts each product (upper half, then lower half) into a signature.
module bist_mult5_core #(
  parameter logic [4:0] SEED_A = 5'h01,
  parameter logic [4:0] SEED_B = 5'h1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enb,
  input  logic [50:0] fault_places,
  input  logic [50:0] fault_control,
  output logic [4:0]  signature,
  output logic [9:0]  cutinp,
  output logic        done
);

  // state    | meaning
  // PH_UPPER | next enabled cycle compacts p[9:5]
  // PH_LOWER | next enabled cycle compacts p[4:0] and advances the operand LFSRs
  typedef enum logic {PH_UPPER = 1'b0, PH_LOWER = 1'b1} phase_t;

  phase_t      phase, phase_nxt;
  logic [4:0]  a, b, sig;
  logic [4:0]  a_nxt, b_nxt, sig_nxt;
  logic        done_q, done_nxt;

  logic [24:0] pp;
  logic [4:0]  row [5];
  logic [4:0]  x_acc;
  logic [5:0]  sum_k;
  logic [4:0]  s_k;
  logic        cy_k;
  logic [9:0]  p;
  logic        unused_fault_sites;

  function automatic logic [4:0] lfsr_step(input logic [4:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

  function automatic logic [4:0] misr_step(input logic [4:0] s, input logic [4:0] m);
    return {s[3] ^ m[4], s[2] ^ m[3], s[1] ^ s[4] ^ m[2], s[0] ^ m[1], s[4] ^ m[0]};
  endfunction

  // Sites 49 and 50 exist on the port but drive nothing in the array.
  assign unused_fault_sites = ^{fault_places[50:49], fault_control[50:49]};

  always_comb begin
    pp = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        pp[5*i+j] = fault_places[5*i+j] ? fault_control[5*i+j] : (a[i] & b[j]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      row[k] = '0;
      for (int i = 0; i < 5; i++) begin
        row[k][i] = pp[5*i+k];
      end
    end
  end

  // Ripple of partial-product rows; each row's sum bits and carry are fault sites.
  always_comb begin
    p     = '0;
    sum_k = '0;
    s_k   = '0;
    cy_k  = 1'b0;
    p[0]  = row[0][0];
    x_acc = {1'b0, row[0][4:1]};
    for (int k = 1; k < 5; k++) begin
      sum_k = {1'b0, x_acc} + {1'b0, row[k]};
      for (int j = 0; j < 5; j++) begin
        s_k[j] = fault_places[25+6*(k-1)+j] ? fault_control[25+6*(k-1)+j] : sum_k[j];
      end
      cy_k  = fault_places[30+6*(k-1)] ? fault_control[30+6*(k-1)] : sum_k[5];
      p[k]  = s_k[0];
      x_acc = {cy_k, s_k[4:1]};
    end
    p[9:5] = x_acc;
  end

  always_comb begin
    a_nxt     = a;
    b_nxt     = b;
    sig_nxt   = sig;
    done_nxt  = done_q;
    phase_nxt = phase;
    if (enb && !done_q) begin
      case (phase)
        PH_UPPER: begin
          sig_nxt   = misr_step(sig, p[9:5]);
          phase_nxt = PH_LOWER;
        end
        default: begin
          sig_nxt   = misr_step(sig, p[4:0]);
          a_nxt     = lfsr_step(a);
          phase_nxt = PH_UPPER;
          if (a_nxt == SEED_A) begin
            b_nxt = lfsr_step(b);
            if (b_nxt == SEED_B) done_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a      <= SEED_A;
      b      <= SEED_B;
      sig    <= '0;
      phase  <= PH_UPPER;
      done_q <= 1'b0;
    end else begin
      a      <= a_nxt;
      b      <= b_nxt;
      sig    <= sig_nxt;
      phase  <= phase_nxt;
      done_q <= done_nxt;
    end
  end

  assign signature = sig;
  assign cutinp    = {b, a};
  assign done      = done_q;

endmodule

// File: tb/tb_bist_mult5_core.sv
// Self-checking bench for bist_mult5_core: constant vectors, hold/reset sequences,
// a random-enable full run and single stuck-at fault runs against an arithmetic model.
module tb_bist_mult5_core;

  logic        clk = 1'b0;
  logic        reset, enb;
  logic [50:0] fault_places, fault_control;
  logic [4:0]  signature;
  logic [9:0]  cutinp;
  logic        done;

  bist_mult5_core dut (
    .clk(clk), .reset(reset), .enb(enb),
    .fault_places(fault_places), .fault_control(fault_control),
    .signature(signature), .cutinp(cutinp), .done(done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed = 0;
  int seq_a[31];
  int seq_b[31];
  int m_n, m_ph, m_sig, m_done, m_site, m_val;

  typedef struct {
    int site;
    int val;
    int ncyc;
    int exp_sig;
    int exp_cut;
  } vec_t;
  vec_t vecs[10];

  function automatic int lfsr_next(int q);
    return ((q << 1) & 31) | (((q >> 4) ^ (q >> 2)) & 1);
  endfunction

  // Polynomial view: multiply by x, reduce by x^5+x^2+1, add input word.
  function automatic int misr_next(int s, int m);
    int t;
    t = (s << 1) & 31;
    if ((s & 16) != 0) t = t ^ 5;
    return t ^ m;
  endfunction

  function automatic int mprod(int a, int b, int site, int val);
    int pp[25];
    int row, x, t, s, cy, p;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        pp[5*i+j] = (a >> i) & (b >> j) & 1;
        if (site == 5*i+j) pp[5*i+j] = val;
      end
    row = 0;
    for (int i = 0; i < 5; i++) row = row | (pp[5*i] << i);
    p = row & 1;
    x = row >> 1;
    for (int k = 1; k < 5; k++) begin
      row = 0;
      for (int i = 0; i < 5; i++) row = row | (pp[5*i+k] << i);
      t  = x + row;
      s  = t & 31;
      cy = (t >> 5) & 1;
      for (int j = 0; j < 5; j++)
        if (site == 25 + 6*(k-1) + j) s = (val != 0) ? (s | (1 << j)) : (s & ~(1 << j));
      if (site == 30 + 6*(k-1)) cy = val;
      p = p | ((s & 1) << k);
      x = (cy << 4) | (s >> 1);
    end
    return p | (x << 5);
  endfunction

  function automatic int full_sig(int site, int val);
    int s, p;
    s = 0;
    for (int n = 0; n < 961; n++) begin
      p = mprod(seq_a[n % 31], seq_b[n / 31], site, val);
      s = misr_next(s, p >> 5);
      s = misr_next(s, p & 31);
    end
    return s;
  endfunction

  function automatic int exp_cut();
    return (seq_b[m_n / 31] << 5) | seq_a[m_n % 31];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit en);
    int p;
    if (en && m_done == 0) begin
      p = mprod(seq_a[m_n % 31], seq_b[m_n / 31], m_site, m_val);
      if (m_ph == 0) begin
        m_sig = misr_next(m_sig, p >> 5);
        m_ph  = 1;
      end else begin
        m_sig = misr_next(m_sig, p & 31);
        m_ph  = 0;
        m_n++;
        if (m_n == 961) begin
          m_done = 1;
          m_n    = 0;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_ph = 0; m_sig = 0; m_done = 0;
  endtask

  task automatic do_reset(input int site, input int val);
    fault_places  = '0;
    fault_control = '0;
    if (site >= 0) begin
      fault_places[site]  = 1'b1;
      fault_control[site] = val[0];
    end
    m_site = site;
    m_val  = val;
    enb    = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input bit en);
    enb = en;
    @(posedge clk);
    #1;
    model_step(en);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_sig"}, int'(signature), m_sig);
    chk({tag, "_cut"}, int'(cutinp), exp_cut());
    chk({tag, "_done"}, int'(done), m_done);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int golden, fs, detected, cnt, site, val, hold_sig, hold_cut;
    int fsites[12];
    int fvals[12];

    reset = 1'b1; enb = 1'b0; fault_places = '0; fault_control = '0;
    seq_a[0] = 5'h01;
    seq_b[0] = 5'h1F;
    for (int i = 1; i < 31; i++) begin
      seq_a[i] = lfsr_next(seq_a[i-1]);
      seq_b[i] = lfsr_next(seq_b[i-1]);
    end
    golden = full_sig(-1, 0);

    vecs[0] = '{-1, 0, 0, 'h00, 'h3E1};
    vecs[1] = '{-1, 0, 1, 'h00, 'h3E1};
    vecs[2] = '{-1, 0, 2, 'h1F, 'h3E2};
    vecs[3] = '{-1, 0, 3, 'h1A, 'h3E2};
    vecs[4] = '{ 0, 0, 2, 'h1E, 'h3E2};
    vecs[5] = '{ 0, 1, 2, 'h1F, 'h3E2};
    vecs[6] = '{25, 0, 2, 'h1D, 'h3E2};
    vecs[7] = '{30, 1, 1, 'h02, 'h3E1};
    vecs[8] = '{30, 1, 2, 'h1B, 'h3E2};
    vecs[9] = '{49, 1, 2, 'h1F, 'h3E2};

    for (int v = 0; v < 10; v++) begin
      do_reset(vecs[v].site, vecs[v].val);
      for (int c = 0; c < vecs[v].ncyc; c++) cycle(1'b1);
      chk($sformatf("vec%0d_sig", v), int'(signature), vecs[v].exp_sig);
      chk($sformatf("vec%0d_cut", v), int'(cutinp), vecs[v].exp_cut);
      chk($sformatf("vec%0d_done", v), int'(done), 0);
    end

    // enb low mid-pair must freeze everything including the phase
    do_reset(-1, 0);
    for (int c = 0; c < 5; c++) cycle(1'b1);
    chk_model("pre_hold");
    hold_sig = int'(signature);
    hold_cut = int'(cutinp);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0);
      chk("hold_sig", int'(signature), hold_sig);
      chk("hold_cut", int'(cutinp), hold_cut);
    end
    cycle(1'b1);
    chk_model("post_hold");
    cycle(1'b1);
    cycle(1'b1);
    chk_model("post_hold2");

    // asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_sig", int'(signature), 0);
    chk("async_rst_cut", int'(cutinp), 'h3E1);
    chk("async_rst_done", int'(done), 0);
    reset = 1'b0;
    model_reset();
    cycle(1'b1);
    cycle(1'b1);
    chk("after_rst_sig", int'(signature), 'h1F);
    chk("after_rst_cut", int'(cutinp), 'h3E2);

    // fault-free full run with random enable, checked every cycle
    do_reset(-1, 0);
    cnt = 0;
    while (m_done == 0 && cnt < 8000) begin
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      chk_model("rand");
      cnt++;
    end
    chk("rand_run_bound", m_done, 1);
    chk("full_done", int'(done), 1);
    chk("full_cut", int'(cutinp), 'h3E1);
    chk("full_golden", int'(signature), golden);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1);
      chk("frozen_sig", int'(signature), golden);
      chk("frozen_cut", int'(cutinp), 'h3E1);
      chk("frozen_done", int'(done), 1);
    end

    // single stuck-at faults: fixed picks across site groups plus random ones
    fsites[0] = 0;  fvals[0] = 0;
    fsites[1] = 24; fvals[1] = 1;
    fsites[2] = 25; fvals[2] = 0;
    fsites[3] = 30; fvals[3] = 1;
    fsites[4] = 43; fvals[4] = 1;
    fsites[5] = 48; fvals[5] = 0;
    for (int i = 6; i < 12; i++) begin
      fsites[i] = int'($urandom_range(0, 48));
      fvals[i]  = int'($urandom_range(0, 1));
    end
    detected = 0;
    for (int f = 0; f < 12; f++) begin
      site = fsites[f];
      val  = fvals[f];
      fs   = full_sig(site, val);
      if (fs != golden) detected++;
      do_reset(site, val);
      for (int c = 0; c < 1921; c++) cycle(1'b1);
      chk($sformatf("fault%0d_sa%0d_done_early", site, val), int'(done), 0);
      cycle(1'b1);
      chk($sformatf("fault%0d_sa%0d_done", site, val), int'(done), 1);
      chk($sformatf("fault%0d_sa%0d_cut", site, val), int'(cutinp), 'h3E1);
      chk($sformatf("fault%0d_sa%0d_sig", site, val), int'(signature), fs);
    end
    $display("[TB] info: %0d of 12 injected faults change the golden signature %0h", detected, golden);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
